fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the combinational instruction ROM (word index = addr[11:2]).
It fetches sequentially, accepts branch/jump redirects, and supports halt/resume.
It presents fetched words to decode through a registered valid/ready stage.
It sits between the instruction ROM and the decode stage of the single-cycle/pipelined CPU.

Parameters:
ADDR_WIDTH, 32, width of PC and ROM address
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC loaded on reset (low 2 bits treated as 0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
imem_addr  output  ADDR_WIDTH  address to instruction ROM; equals pc register
imem_data  input  DATA_WIDTH  ROM word, combinational from imem_addr
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  ADDR_WIDTH  redirect target
halt_req  input  1  request to stop fetching
resume  input  1  restart fetching from current pc
inst_valid  output  1  inst_out/inst_pc hold a valid instruction
inst_ready  input  1  decode accepts instruction
inst_out  output  DATA_WIDTH  fetched instruction
inst_pc  output  ADDR_WIDTH  address of inst_out
running  output  1  high when state is RUN
misalign  output  1  sticky: a redirect_pc with [1:0]!=0 was received
fetch_count  output  32  number of completed handshakes, wraps at 2^32

Behaviour:
- Reset (rst_n=0 at rising edge) applies regardless of state or in-flight instruction:
  - pc=RESET_PC with [1:0] forced to 0; state=IDLE.
  - inst_valid=0, inst_out=0, inst_pc=0, running=0, misalign=0, fetch_count=0.
- States:
  - IDLE: after reset; unconditionally goes to RUN on the next edge; no load.
  - RUN: fetching.
  - HALT: no loads.
- Transitions:
  - RUN->HALT when halt_req=1.
  - HALT->RUN when resume=1 and halt_req=0. If halt_req and resume are both 1, stay HALT.
- load = (state==RUN) && !halt_req && !redirect_valid && (!inst_valid || inst_ready).
  - On load: inst_out<=imem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4.
  - pc addition is modulo 2^ADDR_WIDTH (0xFFFF_FFFC -> 0).
- Handshake:
  - Transfer occurs when inst_valid && inst_ready; fetch_count increments by 1 on each transfer.
  - If inst_valid=1 and inst_ready=0, inst_out/inst_pc/inst_valid hold unchanged.
  - If inst_ready=1 and a load occurs in the same cycle, the next word replaces the current one back-to-back: 1 instruction/cycle throughput.
  - If inst_ready=1 with no load, inst_valid<=0.
- Redirect (any state except reset):
  - pc<=redirect_pc with [1:0] cleared.
  - inst_valid<=0 (flush), unless the current word is transferred in the same cycle; that transfer still counts, then inst_valid goes to 0.
  - misalign<=1 if redirect_pc[1:0]!=0.
  - Redirect has priority over load.
  - First target word appears with inst_valid=1 one edge after the redirect edge (if RUN, no halt_req).
- Halt:
  - An already-valid instruction remains presented and can still transfer while in HALT.
  - No new loads occur.
  - pc is frozen except by redirect.
- Simultaneous redirect_valid+halt_req in RUN: pc takes the target, output is flushed, state goes to HALT.
- Startup latency: the first rising edge with rst_n=1 moves IDLE->RUN. The second edge loads the word at RESET_PC (inst_valid=1, inst_pc=RESET_PC).
- running is a registered decode of state.

Test Plan:
- Reset then inst_ready=1 constant, ROM[i]=0x1000+i -> inst_valid rises after 2nd edge; inst_pc 0,4,8,12 with inst_out 0x1000..0x1003 on consecutive cycles; fetch_count=4 after 4 transfers.
- Backpressure: inst_ready=0 for 3 cycles while inst_pc=8 -> inst_out/inst_pc hold 0x1002/8, pc stays 12; inst_ready=1 -> next cycle inst_pc=12; no word lost or duplicated.
- Redirect to 0x40 while inst_pc=8 valid and inst_ready=1 -> fetch_count increments once, next edge inst_valid=0, following edge inst_pc=0x40 with ROM[16]; redirect 0x43 -> misalign=1, fetch from 0x40.
- halt_req while inst_valid=1, inst_ready=0 -> state HALT, running=0, word held; inst_ready=1 -> transfers, inst_valid=0, no further loads; resume with halt_req=1 -> stays HALT; resume alone -> next word at the following pc.
- pc wrap: redirect to 0xFFFF_FFFC -> inst_pc 0xFFFF_FFFC then 0x0000_0000.
- rst_n=0 mid-stream with inst_valid=1 -> next edge all outputs 0, pc=RESET_PC, IDLE; restart sequence matches scenario 1.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: instruction ROM address/data plus the valid/ready stage
// that hands fetched words to decode.
interface fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_out;
  logic [ADDR_WIDTH-1:0] inst_pc;

  // Fetch controller side
  modport master (
    output imem_addr,
    input  imem_data,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc
  );

  // ROM + decode side
  modport slave (
    input  imem_addr,
    output imem_data,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM,
// handles redirects and halt/resume, and presents words to decode through
// a single registered valid/ready stage.
//
// state | meaning
// IDLE  | just out of reset, moves to RUN on the next edge, no loads
// RUN   | fetching one word per cycle when the output stage can take it
// HALT  | no loads; a presented word may still drain; pc moves only on redirect
module fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_ctrl_if.master          bus,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  running,
  output logic                  misalign,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_INIT = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0] inst_out_q, inst_out_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  running_q, running_d;
  logic                  misalign_q, misalign_d;
  logic [31:0]           fetch_count_q, fetch_count_d;
  logic                  xfer;
  logic                  load;

  // Next-state: redirect beats load; a transfer in the redirect cycle still counts
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    inst_out_d    = inst_out_q;
    inst_pc_d     = inst_pc_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    xfer = inst_valid_q && bus.inst_ready;
    load = (state_q == S_RUN) && !halt_req && !redirect_valid &&
           (!inst_valid_q || bus.inst_ready);

    if (xfer) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (redirect_valid) begin
      pc_d         = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      inst_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (load) begin
      inst_out_d   = bus.imem_data;
      inst_pc_d    = pc_q;
      inst_valid_d = 1'b1;
      pc_d         = pc_q + ADDR_WIDTH'(4);
    end else if (xfer) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (halt_req) state_d = S_HALT;
      S_HALT:  if (resume && !halt_req) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_INIT;
      inst_valid_q  <= 1'b0;
      inst_out_q    <= '0;
      inst_pc_q     <= '0;
      running_q     <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      inst_out_q    <= inst_out_d;
      inst_pc_q     <= inst_pc_d;
      running_q     <= running_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_out   = inst_out_q;
  assign bus.inst_pc    = inst_pc_q;
  assign running        = running_q;
  assign misalign       = misalign_q;
  assign fetch_count    = fetch_count_q;

endmodule
